// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: host pushes at full clock rate while the
// drain FSM launches one byte at a time into din/wr_en, pacing on tx_busy.
module uart_tx_fifo #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [7:0]        push_data,
    input  logic              ovf_clr,
    input  logic              tx_busy,
    output logic [7:0]        tx_din,
    output logic              tx_wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t              state_reg;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W-1:0]   rd_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic [TMO_W-1:0]    tmo_reg;
    logic                overflow_reg;
    logic                pop;
    logic                push_ok;

    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (ADDR_W+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign pop     = (state_reg == IDLE) && !empty && !tx_busy;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // A dropped push outranks a clear in the same cycle.
            if (push && !push_ok) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            tx_din    <= 8'h00;
            tx_wr_en  <= 1'b0;
            tmo_reg   <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (pop) begin
                        tx_din    <= mem[rd_ptr_reg];
                        tx_wr_en  <= 1'b1;
                        state_reg <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_wr_en  <= 1'b0;
                    tmo_reg   <= '0;
                    state_reg <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // If the transmitter never acknowledges, the byte is abandoned.
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                        if (tmo_reg == TMO_W'(BUSY_TIMEOUT - 1)) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized traffic, with a simple
// transmitter model driving tx_busy and a log of every launched byte.
module tb_uart_tx_fifo;

    localparam int DEPTH      = 8;
    localparam int MODE_MODEL = 0;
    localparam int MODE_HIGH  = 1;
    localparam int MODE_LOW   = 2;
    localparam int FRAME      = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_busy;
    logic [7:0] tx_din;
    logic       tx_wr_en;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int mode = MODE_HIGH;
    int busy_left = 0;
    int wide_cnt = 0;
    int busy_viol = 0;
    logic prev_wr = 1'b0;
    logic busy_at_edge = 1'b0;
    logic [7:0] tx_log[$];
    int tx_cyc[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(3), .BUSY_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .ovf_clr   (ovf_clr),
        .tx_busy   (tx_busy),
        .tx_din    (tx_din),
        .tx_wr_en  (tx_wr_en),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    always #10 clk = ~clk;

    assign tx_busy = (mode == MODE_HIGH) || (mode == MODE_MODEL && busy_left != 0);

    always @(posedge clk) begin
        cycle++;
        busy_at_edge = tx_busy;
    end

    // Transmitter model: busy is seen from the edge after a launch for FRAME edges.
    always @(negedge clk) begin
        if (mode == MODE_MODEL && rst_n) begin
            if (tx_wr_en) busy_left = FRAME;
            else if (busy_left > 0) busy_left--;
        end else begin
            busy_left = 0;
        end
        if (rst_n && tx_wr_en) begin
            tx_log.push_back(tx_din);
            tx_cyc.push_back(cycle);
            if (prev_wr) wide_cnt++;
            if (busy_at_edge) busy_viol++;
        end
        prev_wr = tx_wr_en;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int m);
        mode = m; push = 1'b0; ovf_clr = 1'b0; push_data = 8'h00;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tx_log.delete(); tx_cyc.delete();
        wide_cnt = 0; busy_viol = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push = 1'b1; push_data = b;
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic wait_launches(input int n, input int budget, output bit ok);
        int left = budget;
        while (tx_log.size() < n && left > 0) begin
            @(negedge clk);
            left--;
        end
        ok = (tx_log.size() >= n);
    endtask

    task automatic test_reset();
        do_reset(MODE_MODEL);
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        tests++; if (tx_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b expected 0", tx_wr_en); end
        tests++; if (tx_din !== 8'h00) begin fails++; $display("FAIL reset_din: got %02h expected 00", tx_din); end
        repeat (100) @(negedge clk);
        tests++; if (tx_log.size() != 0) begin fails++; $display("FAIL idle_launches: got %0d expected 0", tx_log.size()); end
        $display("[TB] reset/idle checked, launches=%0d", tx_log.size());
    endtask

    task automatic test_single_byte();
        bit ok;
        do_reset(MODE_MODEL);
        push = 1'b1; push_data = 8'hA5;
        @(negedge clk);
        push = 1'b0;
        tests++; if (tx_wr_en !== 1'b0) begin fails++; $display("FAIL single_early: got %b expected 0", tx_wr_en); end
        tests++; if (count !== 4'd1) begin fails++; $display("FAIL single_count1: got %0d expected 1", count); end
        @(negedge clk);
        tests++; if (tx_wr_en !== 1'b1) begin fails++; $display("FAIL single_latency: got %b expected 1", tx_wr_en); end
        tests++; if (tx_din !== 8'hA5) begin fails++; $display("FAIL single_din: got %02h expected a5", tx_din); end
        wait_launches(1, 20, ok);
        repeat (20) @(negedge clk);
        tests++; if (tx_log.size() != 1) begin fails++; $display("FAIL single_launches: got %0d expected 1", tx_log.size()); end
        tests++; if (wide_cnt != 0) begin fails++; $display("FAIL single_pulse_width: got %0d wide pulses expected 0", wide_cnt); end
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL single_drained: got count=%0d empty=%b expected 0/1", count, empty); end
        tests++; if (tx_din !== 8'hA5) begin fails++; $display("FAIL single_din_hold: got %02h expected a5", tx_din); end
        $display("[TB] single byte a5 launched %0d time(s)", tx_log.size());
    endtask

    task automatic test_burst();
        bit ok;
        do_reset(MODE_HIGH);
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        tests++; if (full !== 1'b1 || count !== 4'd8) begin fails++; $display("FAIL burst_full: got full=%b count=%0d expected 1/8", full, count); end
        mode = MODE_MODEL;
        wait_launches(8, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL burst_timeout: got %0d launches expected 8", tx_log.size()); end
        for (int i = 0; i < tx_log.size() && i < 8; i++) begin
            tests++; if (tx_log[i] !== 8'(i + 1)) begin fails++; $display("FAIL burst_order[%0d]: got %02h expected %02h", i, tx_log[i], 8'(i + 1)); end
        end
        for (int i = 1; i < tx_cyc.size() && i < 8; i++) begin
            tests++; if (tx_cyc[i] - tx_cyc[i-1] != FRAME + 2) begin fails++; $display("FAIL burst_gap[%0d]: got %0d expected %0d", i, tx_cyc[i] - tx_cyc[i-1], FRAME + 2); end
        end
        tests++; if (busy_viol != 0 || wide_cnt != 0) begin fails++; $display("FAIL burst_handshake: got busy_viol=%0d wide=%0d expected 0/0", busy_viol, wide_cnt); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL burst_empty: got %b expected 1", empty); end
        $display("[TB] burst of 8 launched %0d bytes", tx_log.size());
    endtask

    task automatic test_overflow();
        bit ok;
        int exp_cnt;
        do_reset(MODE_HIGH);
        for (int i = 0; i < 10; i++) begin
            push_byte(8'(8'h10 + i));
            exp_cnt = (i + 1 < DEPTH) ? i + 1 : DEPTH;
            tests++; if (count !== 4'(exp_cnt)) begin fails++; $display("FAIL ovf_count[%0d]: got %0d expected %0d", i, count, exp_cnt); end
            tests++; if (overflow !== (i >= DEPTH)) begin fails++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, overflow, i >= DEPTH); end
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        push = 1'b1; push_data = 8'hEE; ovf_clr = 1'b1;
        @(negedge clk);
        push = 1'b0; ovf_clr = 1'b0;
        tests++; if (overflow !== 1'b1 || count !== 4'd8) begin fails++; $display("FAIL ovf_set_wins: got ovf=%b count=%0d expected 1/8", overflow, count); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        mode = MODE_MODEL;
        wait_launches(8, 200, ok);
        repeat (30) @(negedge clk);
        tests++; if (tx_log.size() != 8) begin fails++; $display("FAIL ovf_launches: got %0d expected 8", tx_log.size()); end
        for (int i = 0; i < tx_log.size() && i < 8; i++) begin
            tests++; if (tx_log[i] !== 8'(8'h10 + i)) begin fails++; $display("FAIL ovf_order[%0d]: got %02h expected %02h", i, tx_log[i], 8'(8'h10 + i)); end
        end
        $display("[TB] overflow: 11 offered, %0d transmitted", tx_log.size());
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [7:0] exp_q[$];
        do_reset(MODE_HIGH);
        for (int i = 0; i < 8; i++) begin
            push_byte(8'(8'h20 + i));
            exp_q.push_back(8'(8'h20 + i));
        end
        exp_q.push_back(8'h99);
        mode = MODE_MODEL; push = 1'b1; push_data = 8'h99;
        @(negedge clk);
        push = 1'b0;
        tests++; if (tx_wr_en !== 1'b1 || tx_din !== 8'h20) begin fails++; $display("FAIL simul_launch: got wr=%b din=%02h expected 1/20", tx_wr_en, tx_din); end
        tests++; if (count !== 4'd8 || full !== 1'b1) begin fails++; $display("FAIL simul_count: got count=%0d full=%b expected 8/1", count, full); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL simul_overflow: got %b expected 0", overflow); end
        wait_launches(9, 300, ok);
        tests++; if (!ok) begin fails++; $display("FAIL simul_timeout: got %0d launches expected 9", tx_log.size()); end
        for (int i = 0; i < tx_log.size() && i < 9; i++) begin
            tests++; if (tx_log[i] !== exp_q[i]) begin fails++; $display("FAIL simul_order[%0d]: got %02h expected %02h", i, tx_log[i], exp_q[i]); end
        end
        $display("[TB] simultaneous push/pop at full: %0d bytes out", tx_log.size());
    endtask

    task automatic test_timeout_and_reset();
        bit ok;
        do_reset(MODE_LOW);
        push_byte(8'h31);
        push_byte(8'h32);
        wait_launches(2, 50, ok);
        tests++; if (!ok) begin fails++; $display("FAIL tmo_launches: got %0d expected 2", tx_log.size()); end
        if (ok) begin
            tests++; if (tx_cyc[1] - tx_cyc[0] != 6) begin fails++; $display("FAIL tmo_gap: got %0d expected 6", tx_cyc[1] - tx_cyc[0]); end
            tests++; if (tx_log[0] !== 8'h31 || tx_log[1] !== 8'h32) begin fails++; $display("FAIL tmo_order: got %02h %02h expected 31 32", tx_log[0], tx_log[1]); end
        end
        do_reset(MODE_HIGH);
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        tests++; if (count !== 4'd3) begin fails++; $display("FAIL rst_queued: got %0d expected 3", count); end
        mode = MODE_LOW;
        @(posedge clk);
        #2;
        tests++; if (tx_wr_en !== 1'b1 || count !== 4'd2) begin fails++; $display("FAIL rst_prelaunch: got wr=%b count=%0d expected 1/2", tx_wr_en, count); end
        rst_n = 1'b0;
        #2;
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin fails++; $display("FAIL rst_async_count: got count=%0d empty=%b expected 0/1", count, empty); end
        tests++; if (tx_wr_en !== 1'b0) begin fails++; $display("FAIL rst_async_wr_en: got %b expected 0", tx_wr_en); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] timeout gap and async reset checked");
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int n;
        do_reset(MODE_MODEL);
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                push_byte(b);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_launches(exp_q.size(), 400, ok);
            tests++; if (!ok) begin fails++; $display("FAIL rand_round%0d: got %0d launches expected %0d", r, tx_log.size(), exp_q.size()); end
            $display("[TB] random round %0d: %0d bytes pushed, %0d total launched", r, n, tx_log.size());
        end
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            tests++; if (tx_log[i] !== exp_q[i]) begin fails++; $display("FAIL rand_order[%0d]: got %02h expected %02h", i, tx_log[i], exp_q[i]); end
        end
        tests++; if (count !== 4'd0 || overflow !== 1'b0) begin fails++; $display("FAIL rand_final: got count=%0d ovf=%b expected 0/0", count, overflow); end
        tests++; if (busy_viol != 0 || wide_cnt != 0) begin fails++; $display("FAIL rand_handshake: got busy_viol=%0d wide=%0d expected 0/0", busy_viol, wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_overflow();
        test_simultaneous();
        test_timeout_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
